// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - mode constants and FSM encoding for the serial universal subtractor
package sub_pkg;

  localparam logic [1:0] MODE_SUB  = 2'b00;
  localparam logic [1:0] MODE_SBB  = 2'b01;
  localparam logic [1:0] MODE_RSUB = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/digit_sub_cell.sv
// rtl/digit_sub_cell.sv - combinational DIGIT-bit subtractor with borrow in/out
module digit_sub_cell #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] diff;

  // The extra top bit of the widened difference is the borrow-out.
  assign diff = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
  assign d    = diff[DIGIT-1:0];
  assign bout = diff[DIGIT];

endmodule

// File: rtl/serial_universal_subtractor.sv
// rtl/serial_universal_subtractor.sv - digit-serial A-B / A-B-1 / B-A / |A-B| with valid/ready
module serial_universal_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             borrow,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [1:0]       mode_q;
  logic             brw;
  logic             sign;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] cx;
  logic [DIGIT-1:0] cy;
  logic [DIGIT-1:0] cd;
  logic             cbout;
  logic [WIDTH-1:0] r_shift;

  // FIX reuses the cell as 0 - r, walking the low digit of r as it rotates.
  always_comb begin
    cx = sa[DIGIT-1:0];
    cy = sb[DIGIT-1:0];
    if (state == FIX) begin
      cx = '0;
      cy = r[DIGIT-1:0];
    end
  end

  digit_sub_cell #(.DIGIT(DIGIT)) u_cell (
    .x    (cx),
    .y    (cy),
    .bin  (brw),
    .d    (cd),
    .bout (cbout)
  );

  assign r_shift   = (r >> DIGIT) | (WIDTH'(cd) << (WIDTH - DIGIT));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      r      <= '0;
      borrow <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      mode_q <= MODE_SUB;
      brw    <= 1'b0;
      sign   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mode == MODE_RSUB) begin
              sa <= b;
              sb <= a;
            end else begin
              sa <= a;
              sb <= b;
            end
            mode_q <= mode;
            brw    <= (mode == MODE_SBB);
            sign   <= 1'b0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          // The cycle after the last digit only inspects the final borrow.
          if (cnt == CW'(NDIG)) begin
            if (mode_q == MODE_ABS && brw) begin
              sign  <= 1'b1;
              brw   <= 1'b0;
              cnt   <= '0;
              state <= FIX;
            end else begin
              borrow <= brw;
              state  <= DONE;
            end
          end else begin
            r   <= r_shift;
            sa  <= sa >> DIGIT;
            sb  <= sb >> DIGIT;
            brw <= cbout;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          r   <= r_shift;
          brw <= cbout;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            borrow <= sign;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_universal_subtractor.sv
// tb/tb_serial_universal_subtractor.sv - scoreboard bench for serial_universal_subtractor
module tb_serial_universal_subtractor;
  import sub_pkg::*;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             borrow;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] er;
    logic             eb;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  serial_universal_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .borrow    (borrow),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: compare on the first cycle of each result, then check stability until consumed.
  logic             seen = 1'b0;
  logic [WIDTH-1:0] held_r;
  logic             held_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", {31'b0, out_valid}, 32'd0);
        end else begin
          chk("result_r", {16'b0, r}, {16'b0, sb_q[0].er});
          chk("result_borrow", {31'b0, borrow}, {31'b0, sb_q[0].eb});
          chk("latency", cyc - sb_q[0].acc, sb_q[0].lat);
        end
        seen   = 1'b1;
        held_r = r;
        held_b = borrow;
      end else begin
        chk("hold_r", {16'b0, r}, {16'b0, held_r});
        chk("hold_borrow", {31'b0, borrow}, {31'b0, held_b});
      end
      if (out_ready) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] im,
                       input logic [15:0] er, input logic eb, input int lat);
    int n;
    @(negedge clk);
    a = ia; b = ib; mode = im; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sb_q.push_back('{er, eb, lat, cyc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode = MODE_SUB;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_r", {16'b0, r}, 32'd0);
    chk("rst_borrow", {31'b0, borrow}, 32'd0);
    rst_n = 1'b1;

    issue(16'd9,    16'd4,    MODE_SUB,  16'h0005, 1'b0, 5);
    issue(16'd9,    16'd4,    MODE_SBB,  16'h0004, 1'b0, 5);
    issue(16'd0,    16'd0,    MODE_SBB,  16'hFFFF, 1'b1, 5);
    issue(16'd5,    16'd9,    MODE_SUB,  16'hFFFC, 1'b1, 5);
    issue(16'd8,    16'd7,    MODE_RSUB, 16'hFFFF, 1'b1, 5);
    issue(16'd5,    16'd9,    MODE_ABS,  16'h0004, 1'b1, 9);
    issue(16'd9,    16'd5,    MODE_ABS,  16'h0004, 1'b0, 5);
    issue(16'd7,    16'd7,    MODE_ABS,  16'h0000, 1'b0, 5);
    issue(16'h1234, 16'h5678, MODE_RSUB, 16'h4444, 1'b0, 5);
    issue(16'h0000, 16'hFFFF, MODE_SUB,  16'h0001, 1'b1, 5);
    issue(16'h0000, 16'hFFFF, MODE_ABS,  16'hFFFF, 1'b1, 9);
    issue(16'h8000, 16'h7FFF, MODE_SBB,  16'h0000, 1'b0, 5);
    drain();

    // Backpressure: result held while a new operation waits at the input.
    out_ready = 1'b0;
    issue(16'd9, 16'd4, MODE_SUB, 16'h0005, 1'b0, 5);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    a = 16'd5; b = 16'd9; mode = MODE_SUB; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_busy", {31'b0, busy}, 32'd1);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accept_busy", {31'b0, busy}, 32'd1);
    chk("bp_accept_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    sb_q.push_back('{16'hFFFC, 1'b1, 5, cyc});
    drain();

    // Reset at the second digit cycle aborts the operation.
    @(negedge clk);
    a = 16'h00F0; b = 16'h0001; mode = MODE_SUB; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_r", {16'b0, r}, 32'd0);
    chk("abort_borrow", {31'b0, borrow}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    issue(16'h00F0, 16'h0001, MODE_SUB, 16'h00EF, 1'b0, 5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_universal_subtractor.md
Name: serial_universal_subtractor

Overview:
Parametrised, digit-serial successor to the 4-bit universal subtractor. It computes a WIDTH-bit subtraction DIGIT bits per clock, LSB digit first, and supports four modes: A-B, A-B-1 (borrow-in), B-A and |A-B|. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area on wide datapaths.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; NDIG = WIDTH/DIGIT digit cycles per pass.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operands and mode are valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  minuend operand (unsigned)
b  in  WIDTH  subtrahend operand (unsigned)
mode  in  2  00 A-B, 01 A-B-1, 10 B-A, 11 |A-B|
out_valid  out  1  r and borrow are valid
out_ready  in  1  consumer accepts the result
r  out  WIDTH  result, modulo 2^WIDTH
borrow  out  1  final borrow-out; in mode 11 it is 1 when A<B
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n low at a clock edge sets state=IDLE, r=0, borrow=0, out_valid=0, busy=0, in_ready=1, and clears internal shift and borrow registers. Reset during CALC, FIX or DONE aborts the operation; no result is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge:
  - latch a, b and mode into shift registers; for mode 10, the operands are swapped.
  - initialise the borrow register to 1 for mode 01, else 0.
  - go to CALC with digit counter = 0.
- CALC: each cycle, the digit cell subtracts the low DIGIT bits with the borrow register. The result digit shifts into r from the MSB end; the operands shift right by DIGIT; the borrow register takes the cell's borrow-out. After NDIG cycles:
  - mode 11 with final borrow=1: latch sign=1, go to FIX.
  - all other cases: borrow <= final borrow, go to DONE.
- FIX (mode 11 only): a second serial pass computes 0 - r over NDIG cycles with borrow-in 0, i.e. two's-complement negation. Afterwards borrow <= 1 and the state goes to DONE.
- DONE: out_valid=1. r and borrow are held stable while out_ready=0. When out_ready=1 at an edge, the state returns to IDLE and out_valid drops in the next cycle.
- in_ready=1 only in IDLE. There is no overlap: a new operation cannot be accepted in the same cycle that a result is consumed. in_valid is ignored outside IDLE.
- Latency: out_valid is first seen high NDIG+1 cycles after the accepting edge. For mode 11 with A<B, it is 2*NDIG+1 cycles. Latency does not depend on the data otherwise.
- Arithmetic: unsigned, wrap-around modulo 2^WIDTH; borrow = 1 exactly when the true mathematical result is negative.
  - Mode 01: borrow=1 when A<=B.
  - Mode 11: A=B gives r=0, borrow=0.
- Simultaneous events: rst_n low overrides every handshake. out_ready is ignored outside DONE.
- r is not cleared between operations. It is only guaranteed valid while out_valid=1.

Decomposition:
- Package sub_pkg holds:
  - mode constants MODE_SUB=2'b00, MODE_SBB=2'b01, MODE_RSUB=2'b10, MODE_ABS=2'b11.
  - state encoding IDLE, CALC, FIX, DONE.
- One sub-module, digit_sub_cell: combinational DIGIT-bit subtractor with inputs x, y, bin and outputs d, bout. It is instantiated once and shared by CALC and FIX through an operand mux.

Test Plan:
- WIDTH=16, DIGIT=4, mode 00, A=9, B=4 -> r=0x0005, borrow=0; out_valid first high 5 cycles after the accepting edge.
- Mode 01, A=9, B=4 -> r=0x0004, borrow=0. Mode 01, A=0, B=0 -> r=0xFFFF, borrow=1.
- Mode 00, A=5, B=9 -> r=0xFFFC, borrow=1. Mode 10, A=8, B=7 -> r=0xFFFF, borrow=1.
- Mode 11, A=5, B=9 -> r=0x0004, borrow=1, latency 9 cycles. Mode 11, A=9, B=5 -> r=0x0004, borrow=0, latency 5 cycles.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> in_ready=0 and r/borrow stable. Raise out_ready -> IDLE next cycle; the new operation is accepted the cycle after.
- Reset mid-CALC (rst_n=0 at the 2nd digit cycle) -> next cycle out_valid=0, r=0, borrow=0, busy=0, in_ready=1; no stale result appears afterwards.
